// File: rtl/traffic_pkg.sv
// Shared light-code, lamp pattern and driver-state definitions for the
// traffic-light FSM and its lamp driver.
package traffic_pkg;

    typedef logic [1:0] light_code_t;
    typedef logic [2:0] lamp_t;   // {red, yellow, green}, 1 = on

    localparam light_code_t LC_GREEN   = 2'b00;
    localparam light_code_t LC_YELLOW  = 2'b01;
    localparam light_code_t LC_RED     = 2'b10;
    localparam light_code_t LC_ILLEGAL = 2'b11;

    localparam lamp_t LAMP_OFF    = 3'b000;
    localparam lamp_t LAMP_GREEN  = 3'b001;
    localparam lamp_t LAMP_YELLOW = 3'b010;
    localparam lamp_t LAMP_RED    = 3'b100;
    localparam lamp_t LAMP_ALL    = 3'b111;

    typedef enum logic [1:0] {
        ST_NORMAL    = 2'b00,
        ST_LAMP_TEST = 2'b01,
        ST_FAULT     = 2'b10
    } drv_state_t;

    // Illegal codes show red so a transient glitch never lights a go lamp.
    function automatic lamp_t lamp_decode(input light_code_t code);
        case (code)
            LC_GREEN:  lamp_decode = LAMP_GREEN;
            LC_YELLOW: lamp_decode = LAMP_YELLOW;
            default:   lamp_decode = LAMP_RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_lamp_driver_if.sv
// Light-code inputs, requests and lamp/status outputs between the traffic
// FSM side (master) and the lamp driver (slave).
interface traffic_lamp_driver_if;
    import traffic_pkg::*;

    light_code_t LA;
    light_code_t LB;
    logic        lamp_test;
    logic        fault_clr;
    lamp_t       lamp_a;
    lamp_t       lamp_b;
    logic        fault;
    logic        test_active;

    modport master (
        output LA, LB, lamp_test, fault_clr,
        input  lamp_a, lamp_b, fault, test_active
    );

    modport slave (
        input  LA, LB, lamp_test, fault_clr,
        output lamp_a, lamp_b, fault, test_active
    );

endinterface

// File: rtl/blink_timer.sv
// Modulo-N cycle counter with a phase bit that toggles on each wrap; clear
// restarts the count with the phase ON.
module blink_timer #(
    parameter int unsigned DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic phase,
    output logic phase_d
);

    localparam int unsigned CW = $clog2(DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d   = cnt + CW'(1);
        phase_d = phase;
        if (clear) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt == LAST) begin
            cnt_d   = '0;
            phase_d = ~phase;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else begin
            cnt   <= cnt_d;
            phase <= phase_d;
        end
    end

endmodule

// File: rtl/traffic_lamp_driver.sv
// Lamp driver behind the two-street traffic FSM: registered decode, conflict
// monitor with latched flashing-red fault, and a timed lamp test.
module traffic_lamp_driver
    import traffic_pkg::*;
#(
    parameter int unsigned BLINK_DIV       = 25_000_000,
    parameter int unsigned CONFLICT_CYCLES = 2,
    parameter int unsigned TEST_CYCLES     = 50_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    traffic_lamp_driver_if.slave bus
);

    localparam int unsigned CCW = $clog2(CONFLICT_CYCLES + 1);
    localparam int unsigned TCW = $clog2(TEST_CYCLES + 1);
    localparam logic [CCW-1:0] CONF_LAST = CCW'(CONFLICT_CYCLES - 1);
    localparam logic [TCW-1:0] TEST_LAST = TCW'(TEST_CYCLES - 1);

    drv_state_t     state_q, state_d;
    logic [CCW-1:0] conf_cnt, conf_d;
    logic [TCW-1:0] test_cnt, test_d;
    lamp_t          lamp_a_d, lamp_b_d;
    logic           bad;
    logic           conflict_hit;
    logic           blink_clear;
    logic           blink_phase;
    logic           blink_phase_d;

    assign blink_clear = (state_q != ST_FAULT);

    blink_timer #(
        .DIV(BLINK_DIV)
    ) u_blink (
        .clk    (clk),
        .reset  (reset),
        .clear  (blink_clear),
        .phase  (blink_phase),
        .phase_d(blink_phase_d)
    );

    // Fault fires on the edge where the bad-cycle count would reach its limit,
    // so the counter itself never needs to hold the terminal value.
    always_comb begin
        bad = (bus.LA == LC_ILLEGAL) || (bus.LB == LC_ILLEGAL) ||
              ((bus.LA != LC_RED) && (bus.LB != LC_RED));
        conflict_hit = bad && (conf_cnt == CONF_LAST);
    end

    always_comb begin
        state_d = state_q;
        conf_d  = conf_cnt;
        test_d  = test_cnt;
        case (state_q)
            ST_NORMAL: begin
                conf_d = bad ? conf_cnt + CCW'(1) : '0;
                if (conflict_hit) begin
                    state_d = ST_FAULT;
                    conf_d  = '0;
                end else if (bus.lamp_test) begin
                    state_d = ST_LAMP_TEST;
                    test_d  = '0;
                end
            end
            ST_LAMP_TEST: begin
                conf_d = bad ? conf_cnt + CCW'(1) : '0;
                if (conflict_hit) begin
                    state_d = ST_FAULT;
                    conf_d  = '0;
                    test_d  = '0;
                end else if (test_cnt == TEST_LAST) begin
                    state_d = ST_NORMAL;
                    test_d  = '0;
                end else begin
                    test_d = test_cnt + TCW'(1);
                end
            end
            ST_FAULT: begin
                conf_d = '0;
                test_d = '0;
                if (bus.fault_clr && !bad) begin
                    state_d = ST_NORMAL;
                end
            end
            default: begin
                state_d = ST_FAULT;
                conf_d  = '0;
                test_d  = '0;
            end
        endcase
    end

    // Lamps are computed from the next state so they move on the same edge.
    always_comb begin
        lamp_a_d = LAMP_RED;
        lamp_b_d = LAMP_RED;
        case (state_d)
            ST_NORMAL: begin
                lamp_a_d = lamp_decode(bus.LA);
                lamp_b_d = lamp_decode(bus.LB);
            end
            ST_LAMP_TEST: begin
                lamp_a_d = LAMP_ALL;
                lamp_b_d = LAMP_ALL;
            end
            ST_FAULT: begin
                lamp_a_d = blink_phase_d ? LAMP_RED : LAMP_OFF;
                lamp_b_d = blink_phase_d ? LAMP_RED : LAMP_OFF;
            end
            default: begin
                lamp_a_d = LAMP_RED;
                lamp_b_d = LAMP_RED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_NORMAL;
            conf_cnt        <= '0;
            test_cnt        <= '0;
            bus.lamp_a      <= LAMP_RED;
            bus.lamp_b      <= LAMP_RED;
            bus.fault       <= 1'b0;
            bus.test_active <= 1'b0;
        end else begin
            state_q         <= state_d;
            conf_cnt        <= conf_d;
            test_cnt        <= test_d;
            bus.lamp_a      <= lamp_a_d;
            bus.lamp_b      <= lamp_b_d;
            bus.fault       <= (state_d == ST_FAULT);
            bus.test_active <= (state_d == ST_LAMP_TEST);
        end
    end

    // The registered phase only feeds the next-phase logic inside the timer.
    logic unused_phase;
    assign unused_phase = blink_phase;

endmodule

// File: tb/tb_traffic_lamp_driver.sv
// Scoreboard bench for traffic_lamp_driver with short timing parameters.
module tb_traffic_lamp_driver;
    import traffic_pkg::*;

    typedef struct packed {
        lamp_t a;
        lamp_t b;
        logic  f;
        logic  t;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t sb[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned step_idx = 0;

    traffic_lamp_driver_if bus();

    traffic_lamp_driver #(
        .BLINK_DIV      (4),
        .CONFLICT_CYCLES(2),
        .TEST_CYCLES    (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Inputs change on the falling edge; the expected result of the following
    // rising edge is queued at the same moment.
    task automatic drive(input logic rst, input light_code_t la, input light_code_t lb,
                         input logic lt, input logic fc,
                         input lamp_t ea, input lamp_t eb, input logic ef, input logic et);
        exp_t e;
        @(negedge clk);
        reset         = rst;
        bus.LA        = la;
        bus.LB        = lb;
        bus.lamp_test = lt;
        bus.fault_clr = fc;
        e.a = ea;
        e.b = eb;
        e.f = ef;
        e.t = et;
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check_eq($sformatf("lamp_a[%0d]", step_idx), bus.lamp_a, e.a);
            check_eq($sformatf("lamp_b[%0d]", step_idx), bus.lamp_b, e.b);
            check_eq($sformatf("fault[%0d]", step_idx), bus.fault, e.f);
            check_eq($sformatf("test_active[%0d]", step_idx), bus.test_active, e.t);
            step_idx++;
        end
    end

    initial begin
        reset         = 1'b1;
        bus.LA        = LC_RED;
        bus.LB        = LC_RED;
        bus.lamp_test = 1'b0;
        bus.fault_clr = 1'b0;

        // Reset state
        drive(1, LC_RED, LC_RED, 0, 0, LAMP_RED, LAMP_RED, 0, 0);

        // Plain decode
        drive(0, LC_GREEN,  LC_RED,    0, 0, LAMP_GREEN,  LAMP_RED,    0, 0);
        drive(0, LC_YELLOW, LC_RED,    0, 0, LAMP_YELLOW, LAMP_RED,    0, 0);
        drive(0, LC_RED,    LC_GREEN,  0, 0, LAMP_RED,    LAMP_GREEN,  0, 0);
        drive(0, LC_RED,    LC_YELLOW, 0, 0, LAMP_RED,    LAMP_YELLOW, 0, 0);

        // Single bad cycle is tolerated, two in a row latch the fault
        drive(0, LC_GREEN, LC_GREEN, 0, 0, LAMP_GREEN, LAMP_GREEN, 0, 0);
        drive(0, LC_RED,   LC_RED,   0, 0, LAMP_RED,   LAMP_RED,   0, 0);
        drive(0, LC_GREEN, LC_GREEN, 0, 0, LAMP_GREEN, LAMP_GREEN, 0, 0);
        drive(0, LC_GREEN, LC_GREEN, 0, 0, LAMP_RED,   LAMP_RED,   1, 0);

        // Flash: ON for 4 edges from entry, OFF for 4, then ON again
        for (int i = 1; i <= 8; i++) begin
            if (i >= 4 && i < 8)
                drive(0, LC_RED, LC_RED, 0, 0, LAMP_OFF, LAMP_OFF, 1, 0);
            else
                drive(0, LC_RED, LC_RED, 0, 0, LAMP_RED, LAMP_RED, 1, 0);
        end

        // Clear refused while inputs are bad, accepted once legal
        drive(0, LC_ILLEGAL, LC_RED,   0, 1, LAMP_RED, LAMP_RED,   1, 0);
        drive(0, LC_RED,     LC_GREEN, 0, 1, LAMP_RED, LAMP_GREEN, 0, 0);

        // Lamp test lasts exactly 3 cycles; a second request does not extend it
        drive(0, LC_RED,   LC_GREEN, 1, 0, LAMP_ALL,   LAMP_ALL,   0, 1);
        drive(0, LC_RED,   LC_GREEN, 1, 0, LAMP_ALL,   LAMP_ALL,   0, 1);
        drive(0, LC_RED,   LC_GREEN, 0, 0, LAMP_ALL,   LAMP_ALL,   0, 1);
        drive(0, LC_RED,   LC_GREEN, 0, 0, LAMP_RED,   LAMP_GREEN, 0, 0);
        drive(0, LC_GREEN, LC_RED,   0, 0, LAMP_GREEN, LAMP_RED,   0, 0);

        // Fault preempts lamp test
        drive(0, LC_RED, LC_RED,     1, 0, LAMP_ALL, LAMP_ALL, 0, 1);
        drive(0, LC_RED, LC_ILLEGAL, 0, 0, LAMP_ALL, LAMP_ALL, 0, 1);
        drive(0, LC_RED, LC_ILLEGAL, 0, 0, LAMP_RED, LAMP_RED, 1, 0);

        // Reset out of FAULT and out of LAMP_TEST
        drive(1, LC_RED,    LC_RED, 0, 0, LAMP_RED,    LAMP_RED, 0, 0);
        drive(0, LC_RED,    LC_RED, 1, 0, LAMP_ALL,    LAMP_ALL, 0, 1);
        drive(1, LC_RED,    LC_RED, 0, 0, LAMP_RED,    LAMP_RED, 0, 0);
        drive(0, LC_YELLOW, LC_RED, 0, 0, LAMP_YELLOW, LAMP_RED, 0, 0);

        @(posedge clk);
        #2;
        check_eq("scoreboard_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
